// File: rtl/register_file_if.sv
// Register-file bus: read/write addressing, write-back data and immediate decode.
// master drives addresses/data, slave is the register file.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic [AW-1:0]     read_reg1;
  logic [AW-1:0]     read_reg2;
  logic [AW-1:0]     write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] sign_extend;
  logic [4:0]        shift_amt;

  modport master (
    output read_reg1, read_reg2,
    output write_reg, write_data,
    output reg_write, imm16,
    input  read_data1, read_data2,
    input  sign_extend, shift_amt
  );

  modport slave (
    input  read_reg1, read_reg2,
    input  write_reg, write_data,
    input  reg_write, imm16,
    output read_data1, read_data2,
    output sign_extend, shift_amt
  );
endinterface

// File: rtl/register_file.sv
// 32-entry MIPS register file, r0 hardwired to zero, with
// same-cycle write-to-read bypass and immediate extension.
module register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input logic             clk,
  input logic             rst_n,
  register_file_if.slave  rf
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic wr_en;
  logic z1, z2;
  logic byp1, byp2;

  assign wr_en = rf.reg_write &&
                 (rf.write_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[rf.write_reg] <= rf.write_data;
    end
  end

  // Reset and r0 force zero; bypass only applies otherwise.
  assign z1 = !rst_n ||
              (rf.read_reg1 == '0);
  assign z2 = !rst_n ||
              (rf.read_reg2 == '0);

  assign byp1 = !z1 && wr_en &&
                (rf.write_reg == rf.read_reg1);
  assign byp2 = !z2 && wr_en &&
                (rf.write_reg == rf.read_reg2);

  always_comb begin
    rf.read_data1 = '0;
    unique case (1'b1)
      z1:      rf.read_data1 = '0;
      byp1:    rf.read_data1 = rf.write_data;
      default: rf.read_data1 = regs[rf.read_reg1];
    endcase
  end

  always_comb begin
    rf.read_data2 = '0;
    unique case (1'b1)
      z2:      rf.read_data2 = '0;
      byp2:    rf.read_data2 = rf.write_data;
      default: rf.read_data2 = regs[rf.read_reg2];
    endcase
  end

  assign rf.sign_extend =
    {{(DATA_W-16){rf.imm16[15]}}, rf.imm16};
  assign rf.shift_amt = rf.imm16[10:6];

  logic unused_aw;
  assign unused_aw = ^AW;
endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file against
// an array-based model of the register contents.
`timescale 1ns/1ps
module tb_register_file;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  logic [31:0] mdl [32];

  register_file_if bus ();

  register_file dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rd(
    input logic [4:0] a
  );
    if (!rst_n)
      return 32'h0;
    if (a == 5'd0)
      return 32'h0;
    if (bus.reg_write && bus.write_reg == a)
      return bus.write_data;
    return mdl[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++)
      mdl[i] = 32'h0;
  endtask

  // Apply the pending write to the model, then cross one edge.
  task automatic step();
    if (rst_n && bus.reg_write &&
        bus.write_reg != 5'd0)
      mdl[bus.write_reg] = bus.write_data;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    bus.reg_write  = 1'b1;
    bus.write_reg  = a;
    bus.write_data = d;
    step();
    bus.reg_write  = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs[0] = 5'd0;
    addrs[1] = 5'd5;
    addrs[2] = 5'd31;
    wr(5'd5, 32'h1234_5678);
    wr(5'd31, 32'hCAFE_0001);
    #2;
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd5;
    bus.write_data = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      bus.read_reg1 = addrs[i];
      bus.read_reg2 = addrs[i];
      #0.5;
      vecs++;
      if (bus.read_data1 !== 32'h0 ||
          bus.read_data2 !== 32'h0) begin
        errs++;
        $display("FAIL reset_r%0d: got %h/%h want 0",
                 addrs[i], bus.read_data1,
                 bus.read_data2);
      end
    end
    bus.reg_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    wr(5'd8, 32'h0000_0002);
    wr(5'd9, 32'h0000_0003);
    bus.read_reg1 = 5'd8;
    bus.read_reg2 = 5'd9;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h2 ||
        bus.read_data2 !== 32'h3) begin
      errs++;
      $display("FAIL write_read: got %h/%h want 2/3",
               bus.read_data1, bus.read_data2);
    end
    bus.read_reg2 = 5'd8;
    #1;
    vecs++;
    if (bus.read_data2 !== bus.read_data1 ||
        bus.read_data2 !== 32'h2) begin
      errs++;
      $display("FAIL same_addr: got %h/%h want 2/2",
               bus.read_data1, bus.read_data2);
    end
  endtask

  task automatic test_zero_reg();
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd0;
    bus.write_data = 32'hDEAD_BEEF;
    bus.read_reg1  = 5'd0;
    bus.read_reg2  = 5'd0;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h0 ||
        bus.read_data2 !== 32'h0) begin
      errs++;
      $display("FAIL zero_same: got %h/%h want 0",
               bus.read_data1, bus.read_data2);
    end
    step();
    bus.reg_write = 1'b0;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h0) begin
      errs++;
      $display("FAIL zero_after: got %h want 0",
               bus.read_data1);
    end
  endtask

  task automatic test_bypass();
    wr(5'd10, 32'h5);
    bus.reg_write  = 1'b0;
    bus.write_reg  = 5'd10;
    bus.write_data = 32'h7;
    bus.read_reg1  = 5'd10;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h5) begin
      errs++;
      $display("FAIL bypass_off: got %h want 5",
               bus.read_data1);
    end
    bus.reg_write = 1'b1;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h7) begin
      errs++;
      $display("FAIL bypass_pre: got %h want 7",
               bus.read_data1);
    end
    step();
    bus.reg_write = 1'b0;
    #1;
    vecs++;
    if (bus.read_data1 !== 32'h7) begin
      errs++;
      $display("FAIL bypass_post: got %h want 7",
               bus.read_data1);
    end
  endtask

  task automatic test_extend();
    logic [15:0] imms [3];
    logic [31:0] exps [3];
    logic [4:0]  shs  [3];
    imms[0] = 16'h8001;
    exps[0] = 32'hFFFF_8001;
    shs[0]  = 5'd0;
    imms[1] = 16'h0040;
    exps[1] = 32'h0000_0040;
    shs[1]  = 5'd1;
    imms[2] = 16'hFFFF;
    exps[2] = 32'hFFFF_FFFF;
    shs[2]  = 5'd31;
    for (int i = 0; i < 3; i++) begin
      bus.imm16 = imms[i];
      #1;
      vecs++;
      if (bus.sign_extend !== exps[i] ||
          bus.shift_amt !== shs[i]) begin
        errs++;
        $display("FAIL extend_%h: got %h/%0d want %h/%0d",
                 imms[i], bus.sign_extend,
                 bus.shift_amt, exps[i], shs[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ese;
    logic [4:0]  esh;
    for (int n = 0; n < 300; n++) begin
      bus.reg_write  = 1'($urandom_range(0, 1));
      bus.write_reg  = 5'($urandom_range(0, 31));
      bus.write_data = $urandom;
      bus.read_reg1  = ($urandom_range(0, 3) == 0)
                     ? bus.write_reg
                     : 5'($urandom_range(0, 31));
      bus.read_reg2  = ($urandom_range(0, 3) == 0)
                     ? bus.write_reg
                     : 5'($urandom_range(0, 31));
      bus.imm16      = 16'($urandom);
      #1;
      e1  = ref_rd(bus.read_reg1);
      e2  = ref_rd(bus.read_reg2);
      ese = 32'($signed(bus.imm16));
      esh = 5'((32'(bus.imm16) / 64) % 32);
      vecs++;
      if (bus.read_data1 !== e1 ||
          bus.read_data2 !== e2 ||
          bus.sign_extend !== ese ||
          bus.shift_amt !== esh) begin
        errs++;
        $display("FAIL rand_%0d: got %h %h %h %0d want %h %h %h %0d",
                 n, bus.read_data1, bus.read_data2,
                 bus.sign_extend, bus.shift_amt,
                 e1, e2, ese, esh);
      end
      step();
    end
    bus.reg_write = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 1; i < 32; i++)
      wr(5'(i), $urandom | 32'h1);
    bus.reg_write  = 1'b1;
    bus.write_reg  = 5'd12;
    bus.write_data = 32'hA5A5_0C0C;
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 32; i++) begin
      bus.read_reg1 = 5'(i);
      bus.read_reg2 = 5'(31 - i);
      #0.05;
      vecs++;
      if (bus.read_data1 !== 32'h0 ||
          bus.read_data2 !== 32'h0) begin
        errs++;
        $display("FAIL rstmid_r%0d: got %h/%h want 0",
                 i, bus.read_data1, bus.read_data2);
      end
    end
    #1.4;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 12)
        continue;
      bus.read_reg1 = 5'(i);
      #0.05;
      vecs++;
      if (bus.read_data1 !== 32'h0) begin
        errs++;
        $display("FAIL rstrel_r%0d: got %h want 0",
                 i, bus.read_data1);
      end
    end
    step();
    bus.reg_write = 1'b0;
    bus.read_reg1 = 5'd12;
    bus.read_reg2 = 5'd13;
    #1;
    d = mdl[12];
    vecs++;
    if (bus.read_data1 !== 32'hA5A5_0C0C ||
        d !== 32'hA5A5_0C0C ||
        bus.read_data2 !== 32'h0) begin
      errs++;
      $display("FAIL rst_first_wr: got %h/%h want a5a50c0c/0",
               bus.read_data1, bus.read_data2);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    model_clear();
    rst_n          = 1'b0;
    bus.read_reg1  = 5'd0;
    bus.read_reg2  = 5'd0;
    bus.write_reg  = 5'd0;
    bus.write_data = 32'h0;
    bus.reg_write  = 1'b0;
    bus.imm16      = 16'h0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_extend();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
